// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: shift-and-add 8x8 multiplier controller with one shared adder and a Start/Done handshake
// Optional build macro EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mult_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               CLOCK_50,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   OperandA,
    input  logic [WIDTH-1:0]   OperandB,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product,
    output logic [3:0]         IterCount
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [3:0]         idx_q, idx_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [3:0]         iter_q, iter_d;
    logic [2*WIDTH-1:0] acc_n;
    logic [WIDTH-1:0]   mplier_n;
    logic [3:0]         idx_n;
    logic               nz, fin;

    // State and datapath registers, all cleared by reset
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            product_q <= '0;
            iter_q    <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            product_q <= product_d;
            iter_q    <= iter_d;
        end
    end

    // One shift-and-add iteration and the register updates it implies
    always_comb begin
        nz       = (OperandA != '0) && (OperandB != '0);
        acc_n    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mplier_n = mplier_q >> 1;
        idx_n    = idx_q + 4'd1;
`ifdef EARLY_EXIT_EN
        fin      = (idx_n == 4'(WIDTH)) || (mplier_n == '0);
`else
        fin      = (idx_n == 4'(WIDTH));
`endif
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        product_d = product_q;
        iter_d    = iter_q;
        if (state_q == IDLE && Start) begin
            if (nz) begin
                mcand_d  = {{WIDTH{1'b0}}, OperandA};
                mplier_d = OperandB;
                acc_d    = '0;
                idx_d    = '0;
            end else begin
                product_d = '0;
                iter_d    = '0;
            end
        end else if (state_q == RUN) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_n;
            acc_d    = acc_n;
            idx_d    = idx_n;
            if (fin) begin
                product_d = acc_n;
                iter_d    = idx_n;
            end
        end
    end

    // Next-state: DONE holds while Start is still high to block auto-retrigger
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = Start ? (nz ? RUN : DONE) : IDLE;
            RUN:     state_d = fin ? DONE : RUN;
            DONE:    state_d = Start ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        Busy      = (state_q == RUN);
        Done      = (state_q == DONE);
        Product   = product_q;
        IterCount = iter_q;
    end
endmodule
